// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet is presented downstream only once its
// last beat is stored, with cut-through release for packets that do not fit the buffer.
module axis_pkt_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEST_WIDTH = 7,
   parameter int USER_WIDTH = 7,
   parameter int DEPTH      = 64
) (
   input  logic                      clk,
   input  logic                      aresetn,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [DEST_WIDTH-1:0]     s_axis_tdest,
   input  logic [USER_WIDTH-1:0]     s_axis_tuser,
   input  logic                      s_axis_tlast,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic [DEST_WIDTH-1:0]     m_axis_tdest,
   output logic [USER_WIDTH-1:0]     m_axis_tuser,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [$clog2(DEPTH):0]    occupancy,
   output logic [$clog2(DEPTH):0]    pkt_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int KW = DATA_WIDTH / 8;
   localparam int EW = DATA_WIDTH + KW + DEST_WIDTH + USER_WIDTH + 1;
   localparam logic [AW:0] ONE = (AW + 1)'(1);

   logic [EW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          aresetn_q;
   logic          flush;
   logic          full;
   logic          empty;
   logic          wr_fire;
   logic          rd_fire;
   logic          wr_pkt;
   logic          rd_pkt;
   logic [EW-1:0] rd_entry;

   // Pointer MSBs differ only when the write side has lapped the read side.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign s_axis_tready = aresetn_q && !full;
   assign wr_fire       = s_axis_tvalid && s_axis_tready;
   assign wr_pkt        = wr_fire && s_axis_tlast;

   assign rd_entry = mem[rd_ptr[AW-1:0]];
   assign {m_axis_tdata, m_axis_tkeep, m_axis_tdest, m_axis_tuser, m_axis_tlast} = rd_entry;
   assign m_axis_tvalid = !empty && ((pkt_count != '0) || flush);
   assign rd_fire       = m_axis_tvalid && m_axis_tready;
   assign rd_pkt        = rd_fire && m_axis_tlast;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tdest, s_axis_tuser, s_axis_tlast};
      end
   end

   always_ff @(posedge clk) begin
      aresetn_q <= aresetn;
      if (!aresetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         pkt_count <= '0;
         flush     <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + ONE;
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + ONE;
         end

         case ({wr_fire, rd_fire})
            2'b10:   occupancy <= occupancy + ONE;
            2'b01:   occupancy <= occupancy - ONE;
            default: occupancy <= occupancy;
         endcase

         case ({wr_pkt, rd_pkt})
            2'b10:   pkt_count <= pkt_count + ONE;
            2'b01:   pkt_count <= pkt_count - ONE;
            default: pkt_count <= pkt_count;
         endcase

         // A full buffer holding no complete packet can only make progress by cutting through.
         if (full && (pkt_count == '0)) begin
            flush <= 1'b1;
         end else if (rd_pkt) begin
            flush <= 1'b0;
         end
      end
   end

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Store-and-forward packet FIFO on the receive side of the AXI-Stream link. It consumes the 64-bit stream produced by the upstream stream driver (data/keep/dest/user/last with valid/ready) and buffers beats. It presents a packet downstream only once its final beat (`last`) has been stored, so downstream logic never sees a packet stall mid-flight. Packets longer than the buffer are released in cut-through mode so that the block cannot deadlock.

## Interface
Parameters:
- `DATA_WIDTH`, 64: stream data width in bits; multiple of 8.
- `DEST_WIDTH`, 7: routing destination width.
- `USER_WIDTH`, 7: sideband user width.
- `DEPTH`, 64: buffer depth in beats; power of two, at least 4.

Ports:
- `clk`  in  1: single clock for all logic.
- `aresetn`  in  1: synchronous, active-low reset.
- `s_axis_tdata`  in  DATA_WIDTH: input beat data.
- `s_axis_tkeep`  in  DATA_WIDTH/8: input byte enables.
- `s_axis_tdest`  in  DEST_WIDTH: input destination.
- `s_axis_tuser`  in  USER_WIDTH: input user sideband.
- `s_axis_tlast`  in  1: final beat of packet.
- `s_axis_tvalid`  in  1: input beat valid.
- `s_axis_tready`  out  1: block can accept a beat.
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tdest`, `m_axis_tuser`, `m_axis_tlast`  out  same widths as the inputs: output beat.
- `m_axis_tvalid`  out  1: output beat valid.
- `m_axis_tready`  in  1: downstream accepts.
- `occupancy`  out  $clog2(DEPTH)+1: beats stored.
- `pkt_count`  out  $clog2(DEPTH)+1: complete packets stored.

## Operation
- **Storage.** Circular buffer of DEPTH entries, each holding {data, keep, dest, user, last}.
  - Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2·DEPTH.
- **Write.** A beat is written when `s_axis_tvalid && s_axis_tready`.
  - `s_axis_tready = aresetn_q && !full`, where `aresetn_q` is a registered copy of `aresetn`.
  - The ready path has no dependence on `s_axis_tvalid`. A producer may wait for ready before raising valid, or raise valid first.
- **Read.** A beat is read when `m_axis_tvalid && m_axis_tready`.
  - `m_axis_t*` is driven from the entry at the read pointer (first-word fall-through).
  - Output fields hold stable while valid is high and ready is low.
- **Eligibility.** `m_axis_tvalid = !empty && (pkt_count != 0 || flush)`.
- **pkt_count.**
  - +1 on a write with `last`.
  - −1 on a read with `last`.
  - Unchanged when both happen in the same cycle.
- **Cut-through fallback (`flush` flag).**
  - Set when `full && pkt_count == 0`.
  - Cleared on a read of a `last` beat.
  - While set, beats of the oversize packet drain as they arrive.
- **occupancy.**
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both happen or neither happens.
- **No modification.** Beats are never dropped, reordered or altered; tkeep/tdest/tuser pass through per beat.

## Timing
- **Reset values** (while `aresetn` is low, and the cycle after it rises): `s_axis_tready=0`, `m_axis_tvalid=0`, `occupancy=0`, `pkt_count=0`, `flush=0`, pointers 0.
  - `s_axis_tready` rises on the second cycle after `aresetn` is sampled high.
  - Output data fields are don't-care while valid is low.
- **Latency.** A `last` beat written at edge N raises `pkt_count` and `m_axis_tvalid` after edge N; the first beat of the packet is on `m_axis` in cycle N+1.
- **Throughput.** One beat per cycle in each direction, with simultaneous read and write.
  - When full, a same-cycle read does not re-enable `s_axis_tready` until the next cycle (ready is based on the registered full flag).
- **Full.** `s_axis_tready=0`. Input beats presented with valid high are held by the producer and are not lost.
- **Empty.** `m_axis_tvalid=0` regardless of `flush`.
- **Reset mid-packet.** All stored beats and counts are discarded; the partial packet on the input is lost and the upstream must restart it.

## Test plan
- **Single packet.** Reset, then write 4 beats with data 0x1111…–0x4444…, keep 0xFF, dest 5, last on beat 4, `m_axis_tready=1` → `m_axis_tvalid` stays 0 until the cycle after beat 4; then 4 consecutive identical beats with last on the 4th; `pkt_count` goes 1→0.
- **Back-pressure hold.** Hold `m_axis_tready=0` for 3 cycles with a packet eligible → output fields constant, `occupancy` unchanged.
- **Upstream handshake style.** Producer waits for ready, then pulses valid for one cycle per beat, with keep 0x0F on the last beat → each pulse is accepted exactly once; keep 0x0F appears on the output last beat.
- **Oversize packet.** DEPTH=64, 100-beat packet, `m_axis_tready=1` → full at beat 64, `flush` set, all 100 beats emerge in order, `flush` cleared after last, `pkt_count` ends at 0.
- **Full/simultaneous.** Fill with 64 one-beat packets → `s_axis_tready=0`, `pkt_count=64`. Read and write in the same cycle after the release → `pkt_count` unchanged and pointers wrap correctly.
- **Reset mid-packet.** Drive `aresetn=0` for 1 cycle after 2 of 5 beats → `occupancy=0`, `m_axis_tvalid=0`, and the next full packet passes cleanly.
